// File: rtl/spi_pkt_pkg.sv
// Shared constants and helpers for the SPI packet receiver slice.
package spi_pkt_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_PKT_WORDS = 2;

  // Ceiling log2, never below 1 so single-value counters still get a bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/spi_pkt_rx_if.sv
// Output word stream of the SPI packet receiver: FWFT head word plus valid/ready.
interface spi_pkt_rx_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] dout;
  logic             dout_last;
  logic             dout_valid;
  logic             dout_ready;

  modport master (
    output dout,
    output dout_last,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_last,
    input  dout_valid,
    output dout_ready
  );

endinterface

// File: rtl/spi_pkt_fifo.sv
// First-word-fall-through FIFO with exact occupancy; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module spi_pkt_fifo
  import spi_pkt_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH + 1,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (cnt_q == LW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign level = cnt_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is cleared on reset so the head word reads as zero afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_pkt_rx.sv
// SPI packet receiver: deserialises din into WIDTH-bit words, tags the last
// word of each packet and buffers words in a FWFT FIFO.
module spi_pkt_rx
  import spi_pkt_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int PKT_WORDS = DEF_PKT_WORDS,
  parameter int DEPTH     = DEF_DEPTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       din,
  input  logic                       sync,
  input  logic                       clr_ovf,
  spi_pkt_rx_if.master               out_if,
  output logic                       word_flg,
  output logic                       pkt_done,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int BW = clog2(WIDTH);
  localparam int WW = clog2(PKT_WORDS);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic             word_flg_q, word_flg_d;
  logic             pkt_done_q, pkt_done_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] sr_shift;
  logic             word_done;
  logic             word_last;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH:0]   fifo_rdata;

  assign sr_shift  = MSB_FIRST ? {sr_q[WIDTH-2:0], din} : {din, sr_q[WIDTH-1:1]};
  assign word_done = en && !sync && (bcnt_q == BW'(WIDTH - 1));
  assign word_last = (wcnt_q == WW'(PKT_WORDS - 1));
  assign push      = word_done;
  assign pop       = out_if.dout_valid && out_if.dout_ready;

  always_comb begin
    sr_d       = sr_q;
    bcnt_d     = bcnt_q;
    wcnt_d     = wcnt_q;
    word_flg_d = 1'b0;
    pkt_done_d = 1'b0;
    ovf_d      = ovf_q;
    if (sync) begin
      bcnt_d = '0;
      wcnt_d = '0;
    end else if (en) begin
      sr_d = sr_shift;
      if (word_done) begin
        bcnt_d     = '0;
        wcnt_d     = word_last ? '0 : wcnt_q + 1'b1;
        word_flg_d = 1'b1;
        pkt_done_d = word_last;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
    // A drop in the same cycle as a clear leaves the flag set.
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (word_done && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q       <= '0;
      bcnt_q     <= '0;
      wcnt_q     <= '0;
      word_flg_q <= 1'b0;
      pkt_done_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      bcnt_q     <= bcnt_d;
      wcnt_q     <= wcnt_d;
      word_flg_q <= word_flg_d;
      pkt_done_q <= pkt_done_d;
      ovf_q      <= ovf_d;
    end
  end

  spi_pkt_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({word_last, sr_shift}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign out_if.dout       = fifo_rdata[WIDTH-1:0];
  assign out_if.dout_last  = fifo_rdata[WIDTH];
  assign out_if.dout_valid = !fifo_empty;
  assign word_flg          = word_flg_q;
  assign pkt_done          = pkt_done_q;
  assign overflow          = ovf_q;

endmodule

// File: doc/spi_pkt_rx.md
# spi_pkt_rx

Parametrised SPI packet receiver. Deserialises a serial `din` stream into WIDTH-bit words, groups words into packets of PKT_WORDS, and buffers completed words in a first-word-fall-through FIFO with a valid/ready handshake. It sits between the SPI pin front-end and the register/command decoder. It is the multi-width, buffered, packet-aware successor to the byte-only `SPI_pkt` shifter.

## Interface
- WIDTH, 8: bits per word, at least 2.
- PKT_WORDS, 2: words per packet, at least 1.
- DEPTH, 4: FIFO entries, a power of two, at least 2.
- MSB_FIRST, 1: 1 = first received bit lands in dout[WIDTH-1]; 0 = first bit lands in dout[0].
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- en  input  1  shift enable; `din` is sampled on every edge where en=1.
- din  input  1  serial data bit.
- sync  input  1  synchronous frame restart; clears the bit and word counters.
- dout  output  WIDTH  FIFO head word.
- dout_last  output  1  head word is the last word of its packet.
- dout_valid  output  1  FIFO not empty.
- dout_ready  input  1  consumer accepts the head word when dout_valid=1.
- word_flg  output  1  one-cycle pulse: a word completed.
- pkt_done  output  1  one-cycle pulse: a packet's final word completed.
- overflow  output  1  sticky: a completed word was dropped.
- clr_ovf  input  1  synchronous clear of overflow.
- level  output  $clog2(DEPTH+1)  FIFO occupancy.

## Operation
- Shift register sr[WIDTH-1:0], bit counter bcnt (0..WIDTH-1), word counter wcnt (0..PKT_WORDS-1).
- en=1, sync=0:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], din}.
  - MSB_FIRST=0: sr <= {din, sr[WIDTH-1:1]}.
  - bcnt increments.
- Edge where en=1 and bcnt=WIDTH-1 (word-complete edge):
  - Assembled word = sr including the current `din`.
  - Push the word with last = (wcnt == PKT_WORDS-1).
  - bcnt wraps to 0. wcnt increments, wrapping to 0 after the last word.
- en=0: sr, bcnt and wcnt hold. A word may be paused mid-way.
- sync=1 has priority over en:
  - bcnt and wcnt go to 0. sr is not required to clear.
  - No push and no flags that cycle.
  - Partial word discarded. FIFO untouched.
- Pop: dout_valid & dout_ready.
- Push while full and no pop:
  - Word dropped; overflow <= 1.
  - word_flg, pkt_done and wcnt still advance normally.
- Push while full with a pop in the same cycle: accepted, level unchanged.
- Push and pop while empty: the push is stored; no bypass.
- Overflow register: clr_ovf=1 clears overflow. If a drop occurs in the same cycle, set wins.
- level is exact at all times and never exceeds DEPTH.
- Reset mid-operation discards the partial word, all FIFO contents, and the packet position.

## Timing
- Reset values:
  - dout = 0, dout_last = 0, dout_valid = 0, word_flg = 0, pkt_done = 0, overflow = 0, level = 0.
  - Internal: sr = 0, bcnt = 0, wcnt = 0, FIFO pointers = 0.
- word_flg and pkt_done are registered. They are high during the cycle after the word-complete edge, for exactly one cycle.
- Latency, empty FIFO: dout and dout_valid become valid in the same cycle word_flg is high.
- dout and dout_last are stable while dout_valid=1 and dout_ready=0.
- Back-to-back words with en held high: word_flg pulses every WIDTH cycles.
- With PKT_WORDS=1, pkt_done equals word_flg.

## Structure
- Shared package `spi_pkt_pkg`:
  - Function `clog2` helper.
  - Constants DEF_WIDTH=8, DEF_DEPTH=4, DEF_PKT_WORDS=2.
- Sub-module `spi_pkt_fifo`:
  - Parameters WIDTH+1 and DEPTH; FWFT.
  - Ports: push, pop, data in/out, full, empty, level.
  - Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- Top level holds the shifter, counters, flag registers and overflow logic.

## Test plan
- Defaults, MSB_FIRST=1, en=1, dout_ready=1, stream 10101011 then 11001100:
  - dout=0xAB with dout_last=0, then dout=0xCC with dout_last=1.
  - word_flg pulses twice; pkt_done pulses once, on the second word.
- MSB_FIRST=0, stream 10101011 -> dout=0xD5.
- Flow control, DEPTH=4, dout_ready=0, five words 0x01..0x05:
  - level=4 and overflow=1; the FIFO then drains 0x01..0x04.
  - clr_ovf=1 -> overflow=0.
- Full FIFO, push and pop in the same cycle -> level stays 4, no overflow, new word appended.
- Pause and restart:
  - en=0 for 3 cycles after bit 4 of 0xAB -> dout still 0xAB.
  - sync=1 after bit 5 of a word -> no push; the next 8 bits form a fresh word, e.g. 0x3C, with dout_last=0.
- rst=0 asserted after bit 3 of word 2 with 1 word queued:
  - All outputs return to reset values.
  - The next complete 0x5A appears with dout_last=0.
